// File: rtl/spi_peripheral_pkg.sv
// Shared SPI transaction types and per-mode bit-count helpers.
package spi_types;

  typedef enum logic [2:0] {
    WRITE_8         = 3'd0,
    WRITE_16        = 3'd1,
    WRITE_8_READ_8  = 3'd2,
    WRITE_8_READ_16 = 3'd3,
    WRITE_8_READ_24 = 3'd4
  } spi_transaction_t;

  function automatic logic mode_valid(input logic [2:0] m);
    return m <= 3'd4;
  endfunction

  function automatic logic [4:0] rx_bits_m1(input spi_transaction_t m);
    return (m == WRITE_16) ? 5'd15 : 5'd7;
  endfunction

  function automatic logic [4:0] tx_bits_m1(input spi_transaction_t m);
    case (m)
      WRITE_8_READ_8:  return 5'd7;
      WRITE_8_READ_16: return 5'd15;
      WRITE_8_READ_24: return 5'd23;
      default:         return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_peripheral_edge.sv
// Input sampler plus rise/fall detect. SPI_PERIPHERAL_SYNC_EN adds a metastability flop.
module spi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

`ifdef SPI_PERIPHERAL_SYNC_EN
  logic meta_q, samp_q, prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      samp_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      samp_q <= meta_q;
      prev_q <= samp_q;
    end
  end
`else
  logic samp_q, prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      samp_q <= d;
      prev_q <= samp_q;
    end
  end
`endif

  assign rise = samp_q & ~prev_q;
  assign fall = ~samp_q & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: receives an 8/16-bit word, optionally returns 8/16/24 read bits.
// Build option SPI_PERIPHERAL_SYNC_EN selects two-flop input synchronisers.
module spi_peripheral import spi_types::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             csb,
  input  logic             mosi,
  output logic             miso,
  input  spi_transaction_t spi_mode,
  input  logic             i_valid,
  input  logic [23:0]      i_data,
  output logic             i_ready,
  output logic             o_valid,
  output logic [15:0]      o_data,
  output logic             o_error
);

  typedef enum logic [2:0] {S_IDLE, S_RXING, S_RX_DONE, S_TXING, S_ERROR} state_t;

  state_t           state_q, state_d;
  spi_transaction_t mode_q, mode_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [15:0]      rx_q, rx_d, o_data_q, o_data_d;
  logic [23:0]      tx_q, tx_d, buf_q, buf_d;
  logic             buf_full_q, buf_full_d, tx_arm_q, tx_arm_d, tx_done_q, tx_done_d;
  logic             miso_q, miso_d, o_valid_q, o_valid_d, o_error_q, o_error_d;
  logic             sclk_rise, sclk_fall, csb_rise, csb_fall, take;

  spi_edge_detect u_sclk (.clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
  spi_edge_detect u_csb  (.clk(clk), .rst(rst), .d(csb),  .rise(csb_rise),  .fall(csb_fall));

  // mosi gets the same sampling depth as sclk so it lines up with sclk_rise
`ifdef SPI_PERIPHERAL_SYNC_EN
  logic mosi_meta_q, mosi_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      mosi_meta_q <= mosi;
      mosi_q      <= mosi_meta_q;
    end
  end
`else
  logic mosi_q;
  always_ff @(posedge clk) begin
    if (rst) mosi_q <= 1'b0;
    else     mosi_q <= mosi;
  end
`endif

  assign i_ready = ~buf_full_q & (state_q != S_TXING);
  assign take    = i_valid & i_ready;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    tx_arm_d   = tx_arm_q;
    tx_done_d  = tx_done_q;
    o_data_d   = o_data_q;
    o_valid_d  = 1'b0;
    o_error_d  = 1'b0;
    buf_d      = take ? i_data : buf_q;
    buf_full_d = buf_full_q | take;
    case (state_q)
      S_IDLE: if (csb_fall) begin
        if (mode_valid(spi_mode)) begin
          state_d = S_RXING;
          mode_d  = spi_mode;
          cnt_d   = rx_bits_m1(spi_mode);
          rx_d    = '0;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_RXING: if (csb_rise) begin
        state_d   = S_IDLE;
        o_error_d = 1'b1;
      end else if (sclk_rise) begin
        rx_d = {rx_q[14:0], mosi_q};
        if (cnt_q == 5'd0) begin
          state_d   = S_RX_DONE;
          o_valid_d = 1'b1;
          o_data_d  = {rx_q[14:0], mosi_q};
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_RX_DONE: if (mode_q == WRITE_8 || mode_q == WRITE_16) begin
        if (csb_rise) state_d = S_IDLE;
      end else begin
        state_d    = S_TXING;
        cnt_d      = tx_bits_m1(mode_q);
        tx_arm_d   = 1'b1;
        tx_done_d  = 1'b0;
        buf_full_d = 1'b0;
        if (buf_full_q)  tx_d = buf_q;
        else if (take)   tx_d = i_data;
        else begin
          tx_d      = '0;
          o_error_d = 1'b1;
        end
      end
      S_TXING: if (csb_rise) begin
        state_d   = S_IDLE;
        o_error_d = ~tx_done_q;
      end else if (sclk_fall && !tx_done_q) begin
        // the fall closing the last write bit only arms the shifter
        if (tx_arm_q)            tx_arm_d  = 1'b0;
        else if (cnt_q == 5'd0)  tx_done_d = 1'b1;
        else                     cnt_d     = cnt_q - 5'd1;
      end
      S_ERROR: ;
      default: state_d = S_IDLE;
    endcase
    miso_d = (state_d == S_TXING && !tx_done_d) ? tx_d[cnt_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= WRITE_8;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_arm_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      miso_q     <= 1'b0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_error_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_arm_q   <= tx_arm_d;
      tx_done_q  <= tx_done_d;
      miso_q     <= miso_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_error_q  <= o_error_d;
    end
  end

  assign miso    = miso_q;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_error = o_error_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Randomised SPI controller bench with a transaction-level reference model and scoreboard.
module tb_spi_peripheral;
  import spi_types::*;

  localparam int HALF = 8;

  logic             clk = 1'b0, rst = 1'b1, sclk = 1'b0, csb = 1'b1, mosi = 1'b0;
  logic             miso, i_ready, o_valid, o_error;
  logic             i_valid = 1'b0;
  logic [23:0]      i_data = '0;
  logic [15:0]      o_data;
  spi_transaction_t spi_mode = WRITE_8;

  spi_peripheral dut (
    .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .mosi(mosi), .miso(miso),
    .spi_mode(spi_mode), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int err_seen = 0, vld_seen = 0;
  logic [15:0] exp_q[$];
  logic        mbuf_full = 1'b0;
  logic [23:0] mbuf = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard: every o_valid pulse must match the next expected word
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        vld_seen++;
        check("valid_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("o_data", o_data, exp_q.pop_front());
      end
      if (o_error) err_seen++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic s);
    mosi = b;
    tick(HALF);
    s = miso;
    sclk = 1'b1;
    tick(HALF);
    sclk = 1'b0;
  endtask

  task automatic preload(input logic [23:0] d);
    int w = 0;
    while (!i_ready && w < 50) begin tick(1); w++; end
    check("preload_ready", i_ready, 1);
    i_valid = 1'b1;
    i_data  = d;
    tick(1);
    i_valid = 1'b0;
    check("ready_after_load", i_ready, 0);
    mbuf_full = 1'b1;
    mbuf      = d;
  endtask

  // k < 0 clocks the full transaction; otherwise csb rises after k bits
  task automatic xfer(input spi_transaction_t m, input logic [15:0] wd, input int k_in,
                      output logic [23:0] rd);
    int wbits, rbits, total, k, nr, exp_err;
    logic consumed, wbad, s;
    logic [31:0] mask;
    logic [23:0] exp_rd;
    wbits = (m == WRITE_16) ? 16 : 8;
    rbits = (m == WRITE_8_READ_8) ? 8 : (m == WRITE_8_READ_16) ? 16 :
            (m == WRITE_8_READ_24) ? 24 : 0;
    total = wbits + rbits;
    k = (k_in < 0) ? total : k_in;
    if (k >= wbits) exp_q.push_back((m == WRITE_16) ? wd : {8'h00, wd[7:0]});
    consumed = (rbits > 0) && (k >= wbits);
    mask     = (32'h1 << rbits) - 32'h1;
    exp_rd   = (consumed && mbuf_full) ? 24'(mbuf & mask[23:0]) : 24'h0;
    exp_err  = int'(k < total) + int'(consumed && !mbuf_full);
    if (consumed) mbuf_full = 1'b0;
    err_seen = 0;
    vld_seen = 0;
    rd   = '0;
    wbad = 1'b0;
    spi_mode = m;
    csb = 1'b0;
    tick(HALF);
    for (int i = 0; i < k; i++) begin
      if (i < wbits) begin
        spi_bit(wd[wbits-1-i], s);
        wbad |= s;
      end else begin
        spi_bit(1'($urandom_range(0, 1)), s);
        rd = {rd[22:0], s};
      end
    end
    tick(HALF);
    csb = 1'b1;
    tick(3 * HALF);
    nr = (k > wbits) ? k - wbits : 0;
    check("write_miso_zero", wbad, 0);
    check("valid_count", vld_seen, 32'(k >= wbits));
    check("error_count", err_seen, exp_err);
    if (nr > 0) check("read_data", rd, exp_rd >> (rbits - nr));
    check("miso_idle", miso, 0);
  endtask

  initial begin
    logic [23:0] rd;
    logic s, any;
    spi_transaction_t m;
    int total, k;

    tick(4);
    check("rst_miso", miso, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_error", o_error, 0);
    check("rst_i_ready", i_ready, 1);
    rst = 1'b0;
    tick(4);

    xfer(WRITE_8, 16'h00A5, -1, rd);
    check("w8_data", o_data, 16'h00A5);
    xfer(WRITE_16, 16'hBEEF, -1, rd);
    check("w16_data", o_data, 16'hBEEF);

    preload(24'h123456);
    xfer(WRITE_8_READ_24, 16'h003C, -1, rd);
    check("r24_cmd", o_data, 16'h003C);
    check("r24_rdata", rd, 24'h123456);
    check("r24_no_error", err_seen, 0);

    xfer(WRITE_8_READ_8, 16'h0081, -1, rd);
    check("underrun_rdata", rd, 0);
    check("underrun_error", err_seen, 1);

    xfer(WRITE_16, 16'h1234, 4, rd);
    check("abort_no_valid", vld_seen, 0);
    check("abort_error", err_seen, 1);
    xfer(WRITE_8, 16'h005A, -1, rd);
    check("after_abort_data", o_data, 16'h005A);

    for (int n = 0; n < 24; n++) begin
      m = spi_transaction_t'($urandom_range(0, 4));
      if (!mbuf_full && $urandom_range(0, 1) == 1) preload(24'($urandom));
      else check("idle_ready", i_ready, 32'(!mbuf_full));
      total = ((m == WRITE_16) ? 16 : 8) + ((m == WRITE_8_READ_8) ? 8 :
              (m == WRITE_8_READ_16) ? 16 : (m == WRITE_8_READ_24) ? 24 : 0);
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total - 1)) : -1;
      xfer(m, 16'($urandom), k, rd);
    end

    // reset in the middle of a read phase
    if (!mbuf_full) preload(24'hABCDEF);
    exp_q.push_back(16'h0077);
    vld_seen = 0;
    spi_mode = WRITE_8_READ_24;
    csb = 1'b0;
    tick(HALF);
    for (int i = 0; i < 13; i++) spi_bit((i < 8) ? 1'(8'h77 >> (7 - i)) : 1'b1, s);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_miso", miso, 0);
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_data", o_data, 0);
    check("midrst_o_error", o_error, 0);
    check("midrst_i_ready", i_ready, 1);
    tick(2);
    rst = 1'b0;
    mbuf_full = 1'b0;
    csb = 1'b1;
    tick(3 * HALF);
    check("midrst_valid_count", vld_seen, 1);

    // unrecognised mode locks up until reset
    vld_seen = 0;
    err_seen = 0;
    any = 1'b0;
    spi_mode = spi_transaction_t'(3'd6);
    csb = 1'b0;
    tick(HALF);
    for (int i = 0; i < 8; i++) begin spi_bit(1'b1, s); any |= s; end
    csb = 1'b1;
    tick(3 * HALF);
    spi_mode = WRITE_8;
    csb = 1'b0;
    tick(HALF);
    for (int i = 0; i < 8; i++) begin spi_bit(1'b1, s); any |= s; end
    csb = 1'b1;
    tick(3 * HALF);
    check("bad_mode_no_valid", vld_seen, 0);
    check("bad_mode_no_error", err_seen, 0);
    check("bad_mode_miso", any, 0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    xfer(WRITE_8, 16'h0033, -1, rd);
    check("recover_data", o_data, 16'h0033);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
